key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
- Receives the 3-bit button code produced by the 7-to-3 front-panel encoder and turns it back into one-hot key events for the game controller.
- Synchronises and debounces the code, then emits exactly one single-cycle event per press.
- Direction keys auto-repeat while held. Decision and reset keys never repeat.
- Sits between the button encoder and the game FSM.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive identical synchronised samples needed to accept a code (>=2).
- REPEAT_DELAY, 500, cycles from the initial direction event to the first repeat (>=1).
- REPEAT_PERIOD, 100, cycles between later repeats (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- code  input  3  encoded button state, asynchronous to clk:
  - 110 reset_blue, 101 reset_red, 100 decision
  - 000 up, 001 down, 010 left, 011 right
  - 111 idle (no key)
- event  output  7  one-hot single-cycle pulse, bit order {reset_blue, reset_red, decision, up, down, left, right} = bits [6:0].
- event_valid  output  1  OR of event, registered.
- held_code  output  3  currently accepted (debounced) code.
- key_held  output  1  high while held_code != 111.

Behaviour:
- Reset, applied on the clk edge with rst=1:
  - sync stages, candidate and held_code <= 111
  - all counters <= 0
  - event, event_valid, key_held <= 0
  - The FSM returns to S_IDLE regardless of state. There is no pending or partial event after reset.
- Synchroniser: two flops, sync1 then sync2.
- Debounce:
  - Register cand and counter cnt (saturating at DEBOUNCE_CYCLES).
  - If sync2 != cand: cand <= sync2, cnt <= 1. Otherwise cnt increments.
  - The code is accepted on the edge where cnt reaches DEBOUNCE_CYCLES, provided cand != held_code.
- Latency: if edge k is the first edge sampling a new stable code, the event is high in the cycle after edge k+DEBOUNCE_CYCLES+1.
- FSM states: S_IDLE, S_HELD, S_REPEAT.
  - S_IDLE (held_code = 111): accept of a key code -> held_code <= code, pulse the matching event bit, go to S_HELD with rcnt <= 0.
  - S_HELD: rcnt counts.
    - Direction code and rcnt == REPEAT_DELAY-1 -> repeat pulse, rcnt <= 0, go to S_REPEAT.
    - Decision and reset codes stay in S_HELD with no further pulses.
  - S_REPEAT: a pulse every REPEAT_PERIOD cycles.
  - From S_HELD or S_REPEAT:
    - Accept of 111 -> S_IDLE, held_code <= 111, no event.
    - Accept of a different key code -> immediate new event for that key, rcnt <= 0, S_HELD.
- Exactly one event bit is ever high. event_valid equals |event in the same cycle.
- Bounces shorter than DEBOUNCE_CYCLES produce no event and do not disturb the repeat timing of the held key. The repeat counter keeps running while cand differs from held_code.
- Key already held when rst deasserts: treated as a new press. The event fires after the normal debounce latency.
- All 8 codes are defined. There is no error output.

Decomposition:
- Shared package key_codes_pkg holds:
  - the 3-bit code constants (CODE_UP..CODE_IDLE)
  - event bit indices (EV_RIGHT=0 .. EV_RESET_BLUE=6)
  - the FSM state enum
- One sub-module, code_debouncer: synchroniser plus debounce counter. It outputs the stable code and a one-cycle accept strobe.
- The top level holds the FSM, the repeat counter and the code-to-one-hot decode.

Test Plan:
(DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless stated)
- Reset with key held: rst=1 for 3 cycles while code=000.
  - During rst: event=0, held_code=111.
  - Release rst at edge r: event=7'b0001000 for one cycle after edge r+5.
- Decision press: code 111->100 at edge k, held 30 cycles, then 111.
  - Single event=7'b0010000 after edge k+5, no repeats.
  - Release gives no event and key_held falls after edge k'+5.
- Bounce rejection: code alternates 011/111 every 2 cycles for 12 cycles, then steady 011 from edge k.
  - Exactly one event=7'b0000001, after edge k+5.
- Auto-repeat: hold 010.
  - event=7'b0000010 at t0, t0+10, t0+13, t0+16.
  - Release stops repeats with no further pulses.
- Direct change: 000 held into S_REPEAT, then 001 without passing through idle.
  - One event=7'b0000100 after debounce.
  - Next repeat exactly 10 cycles later.
- Reset mid-repeat: rst=1 for one edge while 011 is repeating.
  - event=0 and held_code=111 after that edge.
  - A re-press fires after the full debounce latency.

Source files
------------

// File: rtl/key_codes_pkg.sv
// Purpose: shared button-code constants, event bit indices and decoder FSM states.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package key_codes_pkg;

  localparam logic [2:0] CODE_UP         = 3'b000;
  localparam logic [2:0] CODE_DOWN       = 3'b001;
  localparam logic [2:0] CODE_LEFT       = 3'b010;
  localparam logic [2:0] CODE_RIGHT      = 3'b011;
  localparam logic [2:0] CODE_DECISION   = 3'b100;
  localparam logic [2:0] CODE_RESET_RED  = 3'b101;
  localparam logic [2:0] CODE_RESET_BLUE = 3'b110;
  localparam logic [2:0] CODE_IDLE       = 3'b111;

  localparam int EV_RIGHT      = 0;
  localparam int EV_LEFT       = 1;
  localparam int EV_DOWN       = 2;
  localparam int EV_UP         = 3;
  localparam int EV_DECISION   = 4;
  localparam int EV_RESET_RED  = 5;
  localparam int EV_RESET_BLUE = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } key_state_t;

  // One-hot event for a button code; idle maps to no event.
  function automatic logic [6:0] code_to_event(input logic [2:0] c);
    logic [6:0] ev;
    ev = '0;
    case (c)
      CODE_RIGHT:      ev[EV_RIGHT]      = 1'b1;
      CODE_LEFT:       ev[EV_LEFT]       = 1'b1;
      CODE_DOWN:       ev[EV_DOWN]       = 1'b1;
      CODE_UP:         ev[EV_UP]         = 1'b1;
      CODE_DECISION:   ev[EV_DECISION]   = 1'b1;
      CODE_RESET_RED:  ev[EV_RESET_RED]  = 1'b1;
      CODE_RESET_BLUE: ev[EV_RESET_BLUE] = 1'b1;
      default:         ev = '0;
    endcase
    return ev;
  endfunction

  // Direction keys (the only ones that auto-repeat) all have code[2] clear.
  function automatic logic is_direction(input logic [2:0] c);
    return ~c[2];
  endfunction

endpackage

// File: rtl/key_event_decoder_debouncer.sv
// Purpose: two-flop synchroniser plus run-length debounce of the 3-bit button code.
// Latency: accept is asserted combinationally in the cycle before cnt reaches DEBOUNCE_CYCLES (code sampled + DEBOUNCE_CYCLES edges).
// Backpressure: none; accept is a single-cycle strobe the consumer must take.
module code_debouncer
  import key_codes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  output logic [2:0] stable,
  output logic       accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    cand;
  logic [CW-1:0] cnt;

  // Synchronise the async code and count how long the synchronised value has been steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= CODE_IDLE;
      sync2 <= CODE_IDLE;
      cand  <= CODE_IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= code;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= CW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Fires once per steady run, on the edge where cnt becomes DEBOUNCE_CYCLES.
  always_comb begin
    stable = cand;
    accept = (sync2 == cand) && (cnt == CNT_LAST);
  end

endmodule

// File: rtl/key_event_decoder.sv
// Purpose: debounced button code -> one-hot single-cycle key events, with auto-repeat on direction keys.
// Latency: event appears in the cycle after edge k+DEBOUNCE_CYCLES+1, k being the first edge sampling the new code.
// Backpressure: none; events are single-cycle pulses. 'event' is a reserved word, so the event bus is key_event.
module key_event_decoder
  import key_codes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  output logic [6:0] key_event,
  output logic       event_valid,
  output logic [2:0] held_code,
  output logic       key_held
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [2:0]    stable;
  logic          accept;
  key_state_t    state;
  logic [RW-1:0] rcnt;

  code_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .code   (code),
    .stable (stable),
    .accept (accept)
  );

  // Key FSM: a newly accepted code always wins over a repeat due in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      held_code   <= CODE_IDLE;
      rcnt        <= '0;
      key_event   <= '0;
      event_valid <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_event   <= '0;
      event_valid <= 1'b0;
      if (accept && (stable != held_code)) begin
        held_code <= stable;
        key_held  <= (stable != CODE_IDLE);
        rcnt      <= '0;
        if (stable == CODE_IDLE) begin
          state <= S_IDLE;
        end else begin
          key_event   <= code_to_event(stable);
          event_valid <= 1'b1;
          state       <= S_HELD;
        end
      end else begin
        case (state)
          S_HELD: begin
            if (is_direction(held_code)) begin
              if (rcnt == DELAY_LAST) begin
                key_event   <= code_to_event(held_code);
                event_valid <= 1'b1;
                rcnt        <= '0;
                state       <= S_REPEAT;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end
          end
          S_REPEAT: begin
            if (rcnt == PERIOD_LAST) begin
              key_event   <= code_to_event(held_code);
              event_valid <= 1'b1;
              rcnt        <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            rcnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Purpose: directed self-checking bench for key_event_decoder (DEBOUNCE=4, DELAY=10, PERIOD=3).
// Latency: n/a.
// Backpressure: n/a.
module tb_key_event_decoder;

  logic       clk;
  logic       rst;
  logic [2:0] code;
  logic [6:0] key_event;
  logic       event_valid;
  logic [2:0] held_code;
  logic       key_held;

  int tests_run;
  int tests_failed;

  key_event_decoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .key_event  (key_event),
    .event_valid(event_valid),
    .held_code  (held_code),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_idle();
    code = 3'b111;
    for (int i = 0; i < 14; i++) step();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    code = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (key_event !== 7'b0 || event_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_event cyc%0d: got %b/%b want 0000000/0", i, key_event, event_valid);
      end
      tests_run++;
      if (held_code !== 3'b111 || key_held !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_held cyc%0d: got %b/%b want 111/0", i, held_code, key_held);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [6:0] exp;
      step();
      exp = (i == 5) ? 7'b0001000 : 7'b0;
      tests_run++;
      if (key_event !== exp || event_valid !== (|exp)) begin
        tests_failed++;
        $display("FAIL held_through_reset r+%0d: got %b/%b want %b/%b", i, key_event, event_valid, exp, |exp);
      end
    end
    tests_run++;
    if (held_code !== 3'b000 || key_held !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_through_reset_code: got %b/%b want 000/1", held_code, key_held);
    end
    release_idle();
  endtask

  task automatic test_decision();
    code = 3'b100;
    for (int i = 0; i < 30; i++) begin
      logic [6:0] exp;
      step();
      exp = (i == 5) ? 7'b0010000 : 7'b0;
      tests_run++;
      if (key_event !== exp || event_valid !== (|exp)) begin
        tests_failed++;
        $display("FAIL decision k+%0d: got %b/%b want %b/%b", i, key_event, event_valid, exp, |exp);
      end
    end
    code = 3'b111;
    for (int j = 0; j < 10; j++) begin
      logic exp_held;
      step();
      exp_held = (j < 5);
      tests_run++;
      if (key_event !== 7'b0 || key_held !== exp_held) begin
        tests_failed++;
        $display("FAIL decision_release k'+%0d: got ev=%b held=%b want ev=0000000 held=%b", j, key_event, key_held, exp_held);
      end
    end
    tests_run++;
    if (held_code !== 3'b111) begin
      tests_failed++;
      $display("FAIL decision_release_code: got %b want 111", held_code);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 12; i++) begin
      code = ((i / 2) % 2 == 0) ? 3'b011 : 3'b111;
      step();
      tests_run++;
      if (key_event !== 7'b0) begin
        tests_failed++;
        $display("FAIL bounce cyc%0d: got %b want 0000000", i, key_event);
      end
    end
    code = 3'b011;
    for (int i = 0; i < 9; i++) begin
      logic [6:0] exp;
      step();
      exp = (i == 5) ? 7'b0000001 : 7'b0;
      tests_run++;
      if (key_event !== exp || event_valid !== (|exp)) begin
        tests_failed++;
        $display("FAIL bounce_steady k+%0d: got %b/%b want %b/%b", i, key_event, event_valid, exp, |exp);
      end
    end
    release_idle();
  endtask

  // Hold left with a one-cycle glitch mid-hold; repeat cadence must be untouched.
  task automatic test_auto_repeat();
    code = 3'b010;
    for (int i = 0; i < 46; i++) begin
      logic [6:0] exp;
      step();
      exp = (i inside {5, 15, 18, 21, 24, 27, 30, 33}) ? 7'b0000010 : 7'b0;
      tests_run++;
      if (key_event !== exp || event_valid !== (|exp)) begin
        tests_failed++;
        $display("FAIL auto_repeat k+%0d: got %b/%b want %b/%b", i, key_event, event_valid, exp, |exp);
      end
      if (i == 11) code = 3'b111;
      if (i == 12) code = 3'b010;
      if (i == 30) code = 3'b111;
    end
    tests_run++;
    if (held_code !== 3'b111 || key_held !== 1'b0) begin
      tests_failed++;
      $display("FAIL auto_repeat_release: got %b/%b want 111/0", held_code, key_held);
    end
  endtask

  task automatic test_direct_change();
    code = 3'b000;
    for (int i = 0; i < 41; i++) begin
      logic [6:0] exp;
      step();
      if (i inside {5, 15, 18, 21})          exp = 7'b0001000;
      else if (i inside {24, 34, 37, 40})    exp = 7'b0000100;
      else                                   exp = 7'b0;
      tests_run++;
      if (key_event !== exp || event_valid !== (|exp)) begin
        tests_failed++;
        $display("FAIL direct_change k+%0d: got %b/%b want %b/%b", i, key_event, event_valid, exp, |exp);
      end
      if (i == 18) code = 3'b001;
    end
    tests_run++;
    if (held_code !== 3'b001) begin
      tests_failed++;
      $display("FAIL direct_change_code: got %b want 001", held_code);
    end
    release_idle();
  endtask

  task automatic test_reset_mid_repeat();
    code = 3'b011;
    for (int i = 0; i < 20; i++) begin
      logic [6:0] exp;
      step();
      exp = (i inside {5, 15, 18}) ? 7'b0000001 : 7'b0;
      tests_run++;
      if (key_event !== exp) begin
        tests_failed++;
        $display("FAIL pre_reset_repeat k+%0d: got %b want %b", i, key_event, exp);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (key_event !== 7'b0 || event_valid !== 1'b0 || held_code !== 3'b111 || key_held !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_repeat_reset: got ev=%b v=%b code=%b held=%b want 0000000 0 111 0",
               key_event, event_valid, held_code, key_held);
    end
    for (int j = 0; j < 9; j++) begin
      logic [6:0] exp;
      step();
      exp = (j == 5) ? 7'b0000001 : 7'b0;
      tests_run++;
      if (key_event !== exp || event_valid !== (|exp)) begin
        tests_failed++;
        $display("FAIL repress_after_reset r+%0d: got %b/%b want %b/%b", j, key_event, event_valid, exp, |exp);
      end
    end
    release_idle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    code         = 3'b000;
    test_reset();
    test_decision();
    test_bounce();
    test_auto_repeat();
    test_direct_change();
    test_reset_mid_repeat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
